// File: rtl/counter_sequencer.sv
// counter_sequencer: drives one single-shot period timer through a burst of
// back-to-back periods, with an optional idle gap, and watches the timer's
// 2-bit state code for protocol violations.
module counter_sequencer #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned REP_W  = 16,
  parameter int unsigned MARGIN = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [REP_W-1:0] repeats_i,
  input  logic [REP_W-1:0] gap_i,
  input  logic [1:0]       timer_status_i,
  output logic             start_o,
  output logic [CNT_W-1:0] n_o,
  output logic             busy_o,
  output logic             tick_o,
  output logic             done_o,
  output logic             error_o,
  output logic [REP_W-1:0] reps_done_o
);

  // Watchdog is one bit wider than the count so period + MARGIN never wraps.
  localparam int unsigned WD_W = CNT_W + 1;

  localparam logic [1:0] TS_IDLE = 2'b00;
  localparam logic [1:0] TS_RUN  = 2'b01;
  localparam logic [1:0] TS_OVF  = 2'b10;
  localparam logic [1:0] TS_BAD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_RUN = 3'd2,
    S_WAIT_OVF = 3'd3,
    S_GAP      = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] period_q;
  logic [REP_W-1:0] repeats_q;
  logic [REP_W-1:0] gap_q;
  logic [WD_W-1:0]  wd_q;
  logic [REP_W-1:0] gap_cnt_q;
  logic [REP_W-1:0] reps_q;
  logic             start_q;
  logic             busy_q;
  logic             tick_q;
  logic             done_q;
  logic             error_q;

  logic [WD_W-1:0]  wd_inc_d;
  logic [WD_W-1:0]  wd_limit_d;
  logic [REP_W-1:0] reps_inc_d;
  logic [REP_W-1:0] gap_cnt_inc_d;
  logic             last_rep_d;

  // Counter increments and the end-of-burst / timeout thresholds.
  always_comb begin
    wd_inc_d      = wd_q + WD_W'(1);
    wd_limit_d    = {1'b0, period_q} + WD_W'(MARGIN);
    reps_inc_d    = reps_q + REP_W'(1);
    gap_cnt_inc_d = (&gap_cnt_q) ? gap_cnt_q : gap_cnt_q + REP_W'(1);
    last_rep_d    = (repeats_q != '0) && (reps_inc_d == repeats_q);
  end

  // Sequencer FSM with registered outputs; abort overrides every state.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      period_q  <= '0;
      repeats_q <= '0;
      gap_q     <= '0;
      wd_q      <= '0;
      gap_cnt_q <= '0;
      reps_q    <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      if (abort_i) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_ERR: begin
            if (arm_i) begin
              period_q  <= period_i;
              repeats_q <= repeats_i;
              gap_q     <= gap_i;
              reps_q    <= '0;
              error_q   <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= S_START;
            end
          end
          S_START: begin
            if (timer_status_i == TS_BAD) begin
              state_q <= S_ERR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else if (timer_status_i == TS_IDLE) begin
              start_q <= 1'b1;
              wd_q    <= '0;
              state_q <= S_WAIT_RUN;
            end
          end
          S_WAIT_RUN: begin
            if (timer_status_i == TS_BAD) begin
              state_q <= S_ERR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else if (timer_status_i == TS_RUN) begin
              wd_q    <= '0;
              state_q <= S_WAIT_OVF;
            end else begin
              wd_q <= wd_inc_d;
              if (wd_inc_d == WD_W'(4)) begin
                state_q <= S_ERR;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
              end
            end
          end
          S_WAIT_OVF: begin
            if ((timer_status_i == TS_BAD) || (timer_status_i == TS_IDLE)) begin
              state_q <= S_ERR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else if (timer_status_i == TS_OVF) begin
              tick_q <= 1'b1;
              reps_q <= reps_inc_d;
              if (last_rep_d) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                gap_cnt_q <= '0;
                state_q   <= S_GAP;
              end
            end else begin
              wd_q <= wd_inc_d;
              if (wd_inc_d > wd_limit_d) begin
                state_q <= S_ERR;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
              end
            end
          end
          S_GAP: begin
            if (timer_status_i == TS_BAD) begin
              state_q <= S_ERR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              gap_cnt_q <= gap_cnt_inc_d;
              if ((gap_cnt_q >= gap_q) && (timer_status_i == TS_IDLE)) begin
                state_q <= S_START;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign start_o     = start_q;
  assign n_o         = period_q;
  assign busy_o      = busy_q;
  assign tick_o      = tick_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign reps_done_o = reps_q;

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Initiator for the single-shot period timer. It programs the terminal count, issues `start` pulses and follows the timer's 2-bit state code (00 idle, 01 counting, 10 overflow) to run a burst of back-to-back periods with an optional idle gap. It reports each completed period and the end of the burst to the register bank, and flags a timer that fails to follow protocol. It sits between the pyrpl register interface and one timer instance, all in the `clk_i` domain.

## Interface
- `CNT_W`, 32: terminal-count width; must match the timer's `N`.
- `REP_W`, 16: repeat and gap counter width.
- `MARGIN`, 16: extra cycles allowed beyond `period` before timeout.
- `clk_i` input 1: system clock.
- `rstn_i` input 1: one clock; reset is synchronous and active-low.
- `arm_i` input 1: one-cycle request to start a burst. Sampled only in IDLE or ERR.
- `abort_i` input 1: stop immediately and return to IDLE.
- `period_i` input CNT_W: terminal count. Latched on an accepted arm.
- `repeats_i` input REP_W: number of periods per burst. 0 means run until abort. Latched on arm.
- `gap_i` input REP_W: minimum idle cycles between an overflow and the next start. Latched on arm.
- `timer_status_i` input 2: timer state code.
- `start_o` output 1: start pulse to the timer.
- `n_o` output CNT_W: terminal count to the timer. Holds the latched period.
- `busy_o` output 1: high in every state except IDLE and ERR.
- `tick_o` output 1: one-cycle pulse per completed period.
- `done_o` output 1: one-cycle pulse when the burst completes.
- `error_o` output 1: sticky protocol error.
- `reps_done_o` output REP_W: number of periods completed in the current or last burst.

## Operation
- Reset (`rstn_i`=0 at a clock edge) puts the block in IDLE. All outputs are 0, including `n_o` and `reps_done_o`.
- States: IDLE, START, WAIT_RUN, WAIT_OVF, GAP, ERR.
- **IDLE**
  - On `arm_i`=1 with `abort_i`=0: latch `period_i`, `repeats_i` and `gap_i`; clear `reps_done_o` and `error_o`; go to START.
- **START**
  - `start_o` = 1 exactly in the cycles where `timer_status_i`==00.
  - When `start_o`=1, go to WAIT_RUN and clear the watchdog.
  - Otherwise stay in START with `start_o`=0.
- **WAIT_RUN**
  - Status 01: go to WAIT_OVF and clear the watchdog.
  - Watchdog reaches 4 without seeing 01: go to ERR.
- **WAIT_OVF**
  - Status 10: pulse `tick_o` and increment `reps_done_o` (wraps at 2^REP_W).
  - If `repeats` != 0 and the new count equals `repeats`: pulse `done_o` in the same cycle and go to IDLE. Otherwise go to GAP and clear the gap counter.
  - Timeout: if the watchdog exceeds `period + MARGIN` (computed CNT_W+1 bits wide, no wrap), go to ERR.
  - Status 00 while in WAIT_OVF: go to ERR.
- **GAP**
  - The gap counter increments every cycle.
  - Leave for START once the gap counter is at least `gap` and status is 00.
  - With `gap`=0, the earliest exit is the cycle after overflow.
- **ERR**
  - `error_o`=1; `start_o`=0.
  - Only `arm_i` (clears the error, re-arms) or reset leaves ERR.
- Status 11 in any non-IDLE state: go to ERR.
- `abort_i`=1 in any state: go to IDLE at the next edge with no `tick_o` and no `done_o`. `reps_done_o` keeps its value; `error_o` keeps its value.
- `arm_i` and `abort_i` high together: abort wins.
- `arm_i` while busy is ignored.
- Latched parameters do not change mid-burst.

## Timing
- All outputs are registered.
- `arm_i` sampled at edge t gives START at t+1. If the timer reads 00, `start_o` is high during t+1 .. t+2.
- The timer reports 01 one cycle after sampling `start`. From the start pulse to overflow is about N+2 cycles.
- Overflow seen at edge k: `tick_o` (and `done_o` on the last period) are high during cycle k+1.
- Gap: the next `start_o` is asserted no earlier than `gap`+1 cycles after `tick_o`.
- Reset mid-burst takes effect at the same edge; `start_o` is 0 in the next cycle.

## Test plan
- Burst: `period`=10, `repeats`=3, `gap`=0, behavioural timer model → 3 `start_o` pulses, 3 `tick_o` pulses, one `done_o` coincident with the third tick, `reps_done_o`=3, `busy_o` low afterwards.
- Gap: `period`=5, `repeats`=2, `gap`=7 → overflow-to-next-`start_o` spacing of at least 8 cycles.
- Start timeout: the model ignores `start`, holding status at 00 → ERR after 4 cycles, `error_o`=1, `busy_o`=0. A new `arm_i` clears `error_o` and retries.
- Overflow timeout: `period`=20, `MARGIN`=16, status stuck at 01 → ERR after 37 cycles in WAIT_OVF. Separately, status 11 injected → ERR the next cycle.
- Continuous run: `repeats`=0, `period`=3 → ticks continue past 2^REP_W wrap-around test with REP_W=4 (`reps_done_o` goes 15 → 0) and `done_o` never asserts. `abort_i` then gives IDLE with no further `start_o`.
- Reset/abort races: `rstn_i` low during WAIT_OVF → all outputs 0 next cycle. `arm_i` and `abort_i` together in IDLE → stays IDLE.
